// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared pipeline types for the decode/execute boundary.
//   XLEN          : datapath width
//   REG_AW        : register index width
//   alu_op_e      : ALU operation selector
//   wb_sel_e      : write-back source selector
//   ctrl_t        : decoded control bundle travelling with an instruction
//   ex_bundle_t   : full contents of the ID/EX pipeline register
//   ctrl_gate()   : forces the control bundle to all-zero for non-valid slots
// -----------------------------------------------------------------------------
package pipe_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_e;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2,
      WB_IMM = 2'd3
   } wb_sel_e;

   typedef struct packed {
      logic    reg_write;
      logic    mem_read;
      logic    mem_write;
      alu_op_e alu_op;
      logic    alu_src;
      wb_sel_e wb_sel;
   } ctrl_t;

   // All-zero control: a slot carrying this has no architectural side effect.
   localparam ctrl_t CTRL_NOP = '{
      reg_write : 1'b0,
      mem_read  : 1'b0,
      mem_write : 1'b0,
      alu_op    : ALU_ADD,
      alu_src   : 1'b0,
      wb_sel    : WB_ALU
   };

   typedef struct packed {
      logic              valid;
      logic [XLEN-1:0]   pc;
      logic [REG_AW-1:0] rs1_addr;
      logic [REG_AW-1:0] rs2_addr;
      logic [REG_AW-1:0] rd_addr;
      logic [XLEN-1:0]   rs1_data;
      logic [XLEN-1:0]   rs2_data;
      logic [XLEN-1:0]   imm;
      ctrl_t             ctrl;
   } ex_bundle_t;

   localparam ex_bundle_t EX_CLEAR = '{
      valid    : 1'b0,
      pc       : {XLEN{1'b0}},
      rs1_addr : {REG_AW{1'b0}},
      rs2_addr : {REG_AW{1'b0}},
      rd_addr  : {REG_AW{1'b0}},
      rs1_data : {XLEN{1'b0}},
      rs2_data : {XLEN{1'b0}},
      imm      : {XLEN{1'b0}},
      ctrl     : CTRL_NOP
   };

   function automatic ctrl_t ctrl_gate(input logic valid, input ctrl_t ctrl);
      ctrl_t res;
      if (valid) begin
         res = ctrl;
      end else begin
         res = CTRL_NOP;
      end
      return res;
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Load-use hazard comparator. A load sitting in EX whose destination is read
// by the instruction in decode cannot be forwarded in time, so decode must
// wait one cycle.
//   ex_valid, ex_mem_read, ex_rd_addr : instruction currently in EX
//   id_valid, id_rs1_addr, id_rs2_addr: instruction currently in decode
//   load_use                          : combinational stall request
// -----------------------------------------------------------------------------
module hazard_detect
   import pipe_pkg::*;
(
   input  logic              ex_valid,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_rd_addr,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1_addr,
   input  logic [REG_AW-1:0] id_rs2_addr,
   output logic              load_use
);

   // Load in EX feeding a source of the decode instruction; x0 never hazards.
   always_comb begin
      load_use = 1'b0;
      if (ex_valid && ex_mem_read && (ex_rd_addr != {REG_AW{1'b0}}) && id_valid &&
          ((ex_rd_addr == id_rs1_addr) || (ex_rd_addr == id_rs2_addr))) begin
         load_use = 1'b1;
      end else begin
         load_use = 1'b0;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with write-through register-file bypass, held
// operand refresh during downstream stalls, flush and load-use bubble insertion.
//   clk, rst_n          : clock, asynchronous active-low reset
//   id_*                : decode-stage instruction, operands, immediate, control
//   wb_wr_en/addr/data  : register-file write port (also used for bypass)
//   ex_stall            : hold EX contents
//   flush               : kill the instruction entering EX
//   ex_*                : registered EX-stage operands
//   id_stall            : combinational load-use stall to fetch/decode
// -----------------------------------------------------------------------------
module id_ex_stage
   import pipe_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [REG_AW-1:0] id_rs1_addr,
   input  logic [REG_AW-1:0] id_rs2_addr,
   input  logic [REG_AW-1:0] id_rd_addr,
   input  logic [XLEN-1:0]   id_rd_data1,
   input  logic [XLEN-1:0]   id_rd_data2,
   input  logic [XLEN-1:0]   id_imm,
   input  ctrl_t             id_ctrl,
   input  logic              wb_wr_en,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic [XLEN-1:0]   wb_data,
   input  logic              ex_stall,
   input  logic              flush,
   output logic              ex_valid,
   output logic [XLEN-1:0]   ex_pc,
   output logic [REG_AW-1:0] ex_rs1_addr,
   output logic [REG_AW-1:0] ex_rs2_addr,
   output logic [REG_AW-1:0] ex_rd_addr,
   output logic [XLEN-1:0]   ex_rs1_data,
   output logic [XLEN-1:0]   ex_rs2_data,
   output logic [XLEN-1:0]   ex_imm,
   output ctrl_t             ex_ctrl,
   output logic              id_stall
);

   ex_bundle_t ex_r;
   ex_bundle_t ex_nxt_s;
   logic       load_use_s;

   // Operand entering EX: x0 is hard zero; a same-cycle write-back wins over
   // the (pre-write) asynchronous register-file read.
   function automatic logic [XLEN-1:0] capture_operand(
      input logic [REG_AW-1:0] rs_addr,
      input logic [XLEN-1:0]   rd_data,
      input logic              wr_en,
      input logic [REG_AW-1:0] wr_addr,
      input logic [XLEN-1:0]   wr_data
   );
      logic [XLEN-1:0] res;
      if (rs_addr == {REG_AW{1'b0}}) begin
         res = {XLEN{1'b0}};
      end else if (wr_en && (wr_addr == rs_addr)) begin
         res = wr_data;
      end else begin
         res = rd_data;
      end
      return res;
   endfunction

   // Operand held in EX: pick up any write to its register so that it is
   // never stale when the stall releases.
   function automatic logic [XLEN-1:0] refresh_operand(
      input logic [REG_AW-1:0] held_addr,
      input logic [XLEN-1:0]   held_data,
      input logic              wr_en,
      input logic [REG_AW-1:0] wr_addr,
      input logic [XLEN-1:0]   wr_data
   );
      logic [XLEN-1:0] res;
      if (wr_en && (wr_addr != {REG_AW{1'b0}}) && (wr_addr == held_addr)) begin
         res = wr_data;
      end else begin
         res = held_data;
      end
      return res;
   endfunction

   hazard_detect u_hazard_detect (
      .ex_valid    (ex_r.valid),
      .ex_mem_read (ex_r.ctrl.mem_read),
      .ex_rd_addr  (ex_r.rd_addr),
      .id_valid    (id_valid),
      .id_rs1_addr (id_rs1_addr),
      .id_rs2_addr (id_rs2_addr),
      .load_use    (load_use_s)
   );

   // Next ID/EX contents, priority flush > ex_stall > load-use > capture.
   always_comb begin
      ex_nxt_s = ex_r;
      if (flush) begin
         ex_nxt_s.valid = 1'b0;
         ex_nxt_s.ctrl  = CTRL_NOP;
      end else if (ex_stall) begin
         ex_nxt_s.rs1_data = refresh_operand(ex_r.rs1_addr, ex_r.rs1_data,
                                             wb_wr_en, wb_addr, wb_data);
         ex_nxt_s.rs2_data = refresh_operand(ex_r.rs2_addr, ex_r.rs2_data,
                                             wb_wr_en, wb_addr, wb_data);
      end else if (load_use_s) begin
         // Bubble; decode keeps its instruction because id_stall is high.
         ex_nxt_s.valid = 1'b0;
         ex_nxt_s.ctrl  = CTRL_NOP;
      end else begin
         ex_nxt_s.valid    = id_valid;
         ex_nxt_s.pc       = id_pc;
         ex_nxt_s.rs1_addr = id_rs1_addr;
         ex_nxt_s.rs2_addr = id_rs2_addr;
         ex_nxt_s.rd_addr  = id_rd_addr;
         ex_nxt_s.rs1_data = capture_operand(id_rs1_addr, id_rd_data1,
                                             wb_wr_en, wb_addr, wb_data);
         ex_nxt_s.rs2_data = capture_operand(id_rs2_addr, id_rd_data2,
                                             wb_wr_en, wb_addr, wb_data);
         ex_nxt_s.imm      = id_imm;
         ex_nxt_s.ctrl     = ctrl_gate(id_valid, id_ctrl);
      end
   end

   // ID/EX pipeline register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_r <= EX_CLEAR;
      end else begin
         ex_r <= ex_nxt_s;
      end
   end

   assign ex_valid    = ex_r.valid;
   assign ex_pc       = ex_r.pc;
   assign ex_rs1_addr = ex_r.rs1_addr;
   assign ex_rs2_addr = ex_r.rs2_addr;
   assign ex_rd_addr  = ex_r.rd_addr;
   assign ex_rs1_data = ex_r.rs1_data;
   assign ex_rs2_data = ex_r.rs2_data;
   assign ex_imm      = ex_r.imm;
   assign ex_ctrl     = ex_r.ctrl;
   assign id_stall    = load_use_s;

endmodule
